// File: rtl/lpc_host_pkg.sv
// Shared LPC definitions: LAD codes, SYNC codes, host state encodings and
// the SYNC code classifier used by the host FSM.
package lpc_host_pkg;

    // LAD codes driven by the host
    localparam logic [3:0] LAD_START    = 4'b0000;
    localparam logic [3:0] CYC_IO_READ  = 4'b0000;
    localparam logic [3:0] CYC_IO_WRITE = 4'b0010;
    localparam logic [3:0] LAD_TAR      = 4'b1111;

    // SYNC codes returned by the peripheral
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    // Host state encodings
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START   = 4'd1;
    localparam logic [3:0] ST_CYCTYPE = 4'd2;
    localparam logic [3:0] ST_ADDR    = 4'd3;
    localparam logic [3:0] ST_WDATA   = 4'd4;
    localparam logic [3:0] ST_TAR1    = 4'd5;
    localparam logic [3:0] ST_TAR2    = 4'd6;
    localparam logic [3:0] ST_SYNC    = 4'd7;
    localparam logic [3:0] ST_RDATA   = 4'd8;
    localparam logic [3:0] ST_FTAR1   = 4'd9;
    localparam logic [3:0] ST_FTAR2   = 4'd10;
    localparam logic [3:0] ST_ABORT   = 4'd11;

    // Classes a SYNC nibble can fall into
    typedef enum logic [1:0] {
        SC_READY,
        SC_WAIT,
        SC_ERROR,
        SC_NONE
    } sync_class_t;

    // Map a sampled SYNC nibble onto its class; unknown codes mean no response
    function automatic sync_class_t sync_class(input logic [3:0] code);
        sync_class_t c;
        c = SC_NONE;
        case (code)
            SYNC_READY:             c = SC_READY;
            SYNC_SWAIT, SYNC_LWAIT: c = SC_WAIT;
            SYNC_ERROR:             c = SC_ERROR;
            default:                c = SC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lpc_host.sv
// LPC host: runs one I/O read or write cycle per accepted request. State and
// LAD drive change on the falling edge; LAD is sampled on the rising edge and
// the FSM reacts to that sample on the following falling edge.
module lpc_host
    import lpc_host_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        lframe_o,
    inout  wire  [3:0]  lad_bus,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [15:0] host_addr_i,
    input  logic [7:0]  host_wdata_i,
    output logic        host_busy_o,
    output logic        host_done_o,
    output logic [7:0]  host_rdata_o,
    output logic        host_err_o
);

    // Wide enough to hold SYNC_TIMEOUT itself
    localparam int WAIT_W = $clog2(SYNC_TIMEOUT + 2);

    logic [3:0]        state;
    logic [1:0]        step;      // nibble index inside ADDR/WDATA/RDATA/ABORT
    logic [15:0]       addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [3:0]        lad_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        nr_cnt;
    logic              lad_oe;
    logic [3:0]        lad_out;
    sync_class_t       sync_cls;

    assign sync_cls    = sync_class(lad_q);
    assign host_busy_o = (state != ST_IDLE);
    assign lad_bus     = lad_oe ? lad_out : 4'bzzzz;

    // Sample LAD on the rising edge for the FSM to consume half a clock later
    always_ff @(posedge clk_i or negedge nrst_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop sees
        // pre-edge values regardless of block evaluation order.
        if (!nrst_i) begin
            lad_q <= 4'b0000;
        end else begin
            lad_q <= lad_bus;
        end
    end

    // Cycle sequencer, request capture, SYNC decode and completion status
    always_ff @(negedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state        <= ST_IDLE;
            step         <= 2'd0;
            addr_q       <= 16'h0000;
            we_q         <= 1'b0;
            wdata_q      <= 8'h00;
            wait_cnt     <= '0;
            nr_cnt       <= 2'd0;
            host_done_o  <= 1'b0;
            host_err_o   <= 1'b0;
            host_rdata_o <= 8'h00;
        end else begin
            host_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host_req_i) begin
                        state      <= ST_START;
                        addr_q     <= host_addr_i;
                        we_q       <= host_we_i;
                        wdata_q    <= host_wdata_i;
                        host_err_o <= 1'b0;
                    end
                end
                ST_START: state <= ST_CYCTYPE;
                ST_CYCTYPE: begin
                    state <= ST_ADDR;
                    step  <= 2'd0;
                end
                ST_ADDR: begin
                    if (step == 2'd3) begin
                        step  <= 2'd0;
                        state <= we_q ? ST_WDATA : ST_TAR1;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (step == 2'd1) begin
                        step  <= 2'd0;
                        state <= ST_TAR1;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                ST_TAR1: state <= ST_TAR2;
                ST_TAR2: begin
                    state    <= ST_SYNC;
                    wait_cnt <= '0;
                    nr_cnt   <= 2'd0;
                end
                ST_SYNC: begin
                    case (sync_cls)
                        SC_READY, SC_ERROR: begin
                            // An error SYNC still completes the data phase
                            if (sync_cls == SC_ERROR) host_err_o <= 1'b1;
                            wait_cnt <= '0;
                            nr_cnt   <= 2'd0;
                            step     <= 2'd0;
                            state    <= we_q ? ST_FTAR1 : ST_RDATA;
                        end
                        SC_WAIT: begin
                            nr_cnt <= 2'd0;
                            if (wait_cnt == WAIT_W'(SYNC_TIMEOUT)) begin
                                state      <= ST_ABORT;
                                step       <= 2'd0;
                                host_err_o <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + WAIT_W'(1);
                            end
                        end
                        default: begin
                            wait_cnt <= '0;
                            if (nr_cnt == 2'd2) begin
                                state      <= ST_ABORT;
                                step       <= 2'd0;
                                host_err_o <= 1'b1;
                            end else begin
                                nr_cnt <= nr_cnt + 2'd1;
                            end
                        end
                    endcase
                end
                ST_RDATA: begin
                    if (step == 2'd0) begin
                        host_rdata_o[3:0] <= lad_q;
                        step              <= 2'd1;
                    end else begin
                        host_rdata_o[7:4] <= lad_q;
                        step              <= 2'd0;
                        state             <= ST_FTAR1;
                    end
                end
                ST_FTAR1: state <= ST_FTAR2;
                ST_FTAR2: begin
                    state       <= ST_IDLE;
                    host_done_o <= 1'b1;
                end
                ST_ABORT: begin
                    if (step == 2'd3) begin
                        step        <= 2'd0;
                        state       <= ST_IDLE;
                        host_done_o <= 1'b1;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // LFRAME# and LAD drive decoded from the current state
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        lframe_o = 1'b1;
        lad_oe   = 1'b0;
        lad_out  = LAD_TAR;
        case (state)
            ST_START: begin
                lframe_o = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = LAD_START;
            end
            ST_CYCTYPE: begin
                lad_oe  = 1'b1;
                lad_out = we_q ? CYC_IO_WRITE : CYC_IO_READ;
            end
            ST_ADDR: begin
                lad_oe = 1'b1;
                case (step)
                    2'd0:    lad_out = addr_q[15:12];
                    2'd1:    lad_out = addr_q[11:8];
                    2'd2:    lad_out = addr_q[7:4];
                    default: lad_out = addr_q[3:0];
                endcase
            end
            ST_WDATA: begin
                lad_oe  = 1'b1;
                lad_out = step[0] ? wdata_q[7:4] : wdata_q[3:0];
            end
            ST_TAR1: begin
                lad_oe  = 1'b1;
                lad_out = LAD_TAR;
            end
            ST_ABORT: begin
                lframe_o = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = LAD_TAR;
            end
            default: ;
        endcase
    end

endmodule
